hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 47 ++++
 rtl/hazard_fwd_sel.sv | 62 ++++++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and select codes for the hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_DM  = 2'd1,
    RES_PC8 = 2'd2
  } res_t;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [2:0] CMP_E_PC8 = 3'b111;
  localparam logic [2:0] CMP_M_ALU = 3'b110;
  localparam logic [2:0] CMP_M_PC8 = 3'b101;
  localparam logic [2:0] CMP_W_ALU = 3'b100;
  localparam logic [2:0] CMP_W_PC8 = 3'b011;
  localparam logic [2:0] CMP_W_DM  = 3'b010;
  localparam logic [2:0] CMP_RF    = 3'b000;

  localparam logic [1:0] FWD_M_ALU = 2'b11;
  localparam logic [1:0] FWD_W_ALU = 2'b10;
  localparam logic [1:0] FWD_W_DM  = 2'b01;
  localparam logic [1:0] FWD_RF    = 2'b00;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    res_t       res;
  } e_rec_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wa;
    res_t       res;
  } m_rec_t;

  typedef struct packed {
    logic [4:0] wa;
    res_t       res;
  } w_rec_t;

  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] wa);
    return (src != 5'd0) && (src == wa);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand evaluator: finds the nearest producing stage and derives its
// readiness (tnew) and the comparator / datapath forwarding select codes.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int FIRST = 0  // 0: D operand sees E/M/W, 1: E operand sees M/W, 2: M operand sees W
) (
  input  logic [4:0] src,
  input  logic [4:0] e_wa,
  input  res_t       e_res,
  input  logic [4:0] m_wa,
  input  res_t       m_res,
  input  logic [4:0] w_wa,
  input  res_t       w_res,
  output logic [2:0] cmp_sel,
  output logic [1:0] fwd_sel,
  output logic [1:0] tnew
);

  logic hit_e, hit_m, hit_w;

  assign hit_e = (FIRST == 0) && reg_hit(src, e_wa);
  assign hit_m = (FIRST <= 1) && reg_hit(src, m_wa);
  assign hit_w = reg_hit(src, w_wa);

  always_comb begin
    cmp_sel = CMP_RF;
    fwd_sel = FWD_RF;
    tnew    = 2'd0;
    if (hit_e) begin
      // jal/jalr put PC+8 on the E-stage output already, so only PC8 is ready here
      case (e_res)
        RES_ALU: tnew = 2'd1;
        RES_DM:  tnew = 2'd2;
        default: cmp_sel = CMP_E_PC8;
      endcase
    end else if (hit_m) begin
      if (m_res == RES_DM) begin
        tnew = 2'd1;
      end else begin
        cmp_sel = (m_res == RES_PC8) ? CMP_M_PC8 : CMP_M_ALU;
        fwd_sel = FWD_M_ALU;
      end
    end else if (hit_w) begin
      case (w_res)
        RES_DM: begin
          cmp_sel = CMP_W_DM;
          fwd_sel = FWD_W_DM;
        end
        RES_PC8: begin
          cmp_sel = CMP_W_PC8;
          fwd_sel = FWD_W_ALU;
        end
        default: begin
          cmp_sel = CMP_W_ALU;
          fwd_sel = FWD_W_ALU;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the five-stage MIPS pipeline.
// Define HAZARD_MDU_EN to build the multiply/divide busy-window counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] wa_D,
  input  logic [1:0] res_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [2:0] F_CMP_A_D,
  output logic [2:0] F_CMP_B_D,
  output logic [1:0] F_ALU_A_E,
  output logic [1:0] F_ALU_B_E,
  output logic [1:0] F_DM_Data_M
);

  e_rec_t e_reg, e_next;
  m_rec_t m_reg;
  w_rec_t w_reg;

  logic [4:0] src     [5];
  logic [2:0] cmp_sel [5];
  logic [1:0] fwd_sel [5];
  logic [1:0] tnew    [5];

  logic hz_stall, md_stall, stall_int;

  assign src[0] = rs_D;
  assign src[1] = rt_D;
  assign src[2] = e_reg.rs;
  assign src[3] = e_reg.rt;
  assign src[4] = m_reg.rt;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_op
      hazard_fwd_sel #(
        .FIRST((gi < 2) ? 0 : ((gi < 4) ? 1 : 2))
      ) u_sel (
        .src     (src[gi]),
        .e_wa    (e_reg.wa),
        .e_res   (e_reg.res),
        .m_wa    (m_reg.wa),
        .m_res   (m_reg.res),
        .w_wa    (w_reg.wa),
        .w_res   (w_reg.res),
        .cmp_sel (cmp_sel[gi]),
        .fwd_sel (fwd_sel[gi]),
        .tnew    (tnew[gi])
      );
    end
  endgenerate

  assign hz_stall = ((tuse_rs_D != TUSE_NONE) && (tuse_rs_D < tnew[0])) ||
                    ((tuse_rt_D != TUSE_NONE) && (tuse_rt_D < tnew[1]));

`ifdef HAZARD_MDU_EN
  logic [3:0] md_cnt_reg, md_cnt_next;

  assign md_stall = (md_use_D || md_start_D) && (md_cnt_reg != 4'd0);

  // A start that is held in D by a stall must not open the busy window yet
  always_comb begin
    md_cnt_next = md_cnt_reg;
    if (md_start_D && !stall_int)
      md_cnt_next = md_div_D ? 4'(DIV_CYC) : 4'(MULT_CYC);
    else if (md_cnt_reg != 4'd0)
      md_cnt_next = md_cnt_reg - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) md_cnt_reg <= 4'd0;
    else       md_cnt_reg <= md_cnt_next;
  end
`else
  logic unused_md;
  localparam int unused_cyc = MULT_CYC + DIV_CYC;
  assign md_stall  = 1'b0;
  assign unused_md = ^{md_start_D, md_div_D, md_use_D};
`endif

  assign stall_int = !reset && (hz_stall || md_stall);

  always_comb begin
    e_next = '0;
    if (!stall_int)
      e_next = '{rs: rs_D, rt: rt_D, wa: wa_D, res: res_t'(res_D)};
  end

  // E/M/W always advance, so a stall can only last until its producer retires
  always_ff @(posedge clk) begin
    if (reset) begin
      e_reg <= '0;
      m_reg <= '0;
      w_reg <= '0;
    end else begin
      e_reg <= e_next;
      m_reg <= '{rt: e_reg.rt, wa: e_reg.wa, res: e_reg.res};
      w_reg <= '{wa: m_reg.wa, res: m_reg.res};
    end
  end

  assign stall       = stall_int;
  assign F_CMP_A_D   = reset ? CMP_RF : cmp_sel[0];
  assign F_CMP_B_D   = reset ? CMP_RF : cmp_sel[1];
  assign F_ALU_A_E   = reset ? FWD_RF : fwd_sel[2];
  assign F_ALU_B_E   = reset ? FWD_RF : fwd_sel[3];
  assign F_DM_Data_M = reset ? FWD_RF : fwd_sel[4];

  logic unused_sel;
  assign unused_sel = ^{cmp_sel[2], cmp_sel[3], cmp_sel[4], fwd_sel[0], fwd_sel[1],
                        tnew[2], tnew[3], tnew[4]};

endmodule
